// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared UART constants: IRQ enable bit indices, default timeout, level width
package uart_rx_ctrl_pkg;

    // Bit positions inside the 4-bit interrupt enable vector {err, ovr, to, lvl}
    localparam int IE_LVL = 0;
    localparam int IE_TO  = 1;
    localparam int IE_OVR = 2;
    localparam int IE_ERR = 3;

    // 4 characters x 11 bits x 16 oversample ticks
    localparam int DEF_TIMEOUT_TICKS = 704;

    // Level counters must represent 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver-to-controller character interface
// Signals: rx_data (received character), rx_ready (character strobe),
//          rx_busy (frame in progress), rx_error (parity/frame error flag).
// master: the UART receiver; slave: uart_rx_ctrl.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic                  rx_busy;
    logic                  rx_error;

    modport master (output rx_data, rx_ready, rx_busy, rx_error);
    modport slave  (input  rx_data, rx_ready, rx_busy, rx_error);
endinterface

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// rtl/uart_rx_ctrl_sync_fifo.sv - synchronous FIFO with zero-latency head (module uart_sync_fifo)
// Ports: clk, rst_n; push/push_data, pop; head (FIFO head, 0 when empty);
//        full, empty, level; push_ack/pop_ack report which requests were performed.
module uart_sync_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int LW = level_width(FIFO_DEPTH),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level,
    output logic                  push_ack,
    output logic                  pop_ack
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;

    assign full  = (level == LW'(FIFO_DEPTH));
    assign empty = (level == '0);

    // A pop on an empty FIFO is ignored; a push on a full FIFO only
    // proceeds when a pop frees the head slot in the same cycle.
    assign pop_ack  = pop & ~empty;
    assign push_ack = push & (~full | pop_ack);

    // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ack) wptr <= wptr + AW'(1);
            if (pop_ack)  rptr <= rptr + AW'(1);
            if (push_ack && !pop_ack)      level <= level + LW'(1);
            else if (!push_ack && pop_ack) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ack) mem[wptr] <= push_data;
    end

    // Forced to zero when empty so the head reads 0 out of reset.
    assign head = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: RX FIFO, sticky errors, char timeout, IRQ
// Ports: clk, rst_n (async active-low); baud_en_16x oversample tick;
//        rx (receiver interface, slave); rx_en receive enable;
//        rd_en / rd_data / rx_empty / rx_full / rx_level register-side FIFO access;
//        thresh, ie interrupt threshold and enables {err, ovr, to, lvl};
//        err_clr clears parity_err/frame_err/overrun_err; timeout; irq.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    localparam int LW = level_width(FIFO_DEPTH),
    localparam int TW = $clog2(TIMEOUT_TICKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_en_16x,
    uart_rx_ctrl_if.slave         rx,
    input  logic                  rx_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [LW-1:0]         rx_level,
    input  logic [LW-1:0]         thresh,
    input  logic [3:0]            ie,
    input  logic                  err_clr,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  timeout,
    output logic                  irq
);

    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS - 1);

    logic          push_req;
    logic          push_ack;
    logic          pop_ack;
    logic          err_q;
    logic          parity_set;
    logic          frame_set;
    logic          overrun_set;
    logic          activity;
    logic [TW-1:0] to_cnt;
    logic          irq_next;

    assign push_req = rx_en & rx.rx_ready;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx.rx_data),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level),
        .push_ack  (push_ack),
        .pop_ack   (pop_ack)
    );

    // rx_error alongside rx_ready flags a parity error on a delivered
    // character; a fresh rx_error with no character is a framing error.
    assign parity_set  = rx_en & rx.rx_ready & rx.rx_error;
    assign frame_set   = rx_en & rx.rx_error & ~err_q & ~rx.rx_ready;
    // A simultaneous pop frees the slot, so full-with-pop is not an overrun.
    assign overrun_set = push_req & ~push_ack;

    assign activity = push_ack | pop_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            err_q       <= rx.rx_error;
            // Set term is ORed last so an event in the clear cycle wins.
            parity_err  <= parity_set  | (parity_err  & ~err_clr);
            frame_err   <= frame_set   | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

    // Idle-character timeout: counts oversample ticks while data sits in
    // the FIFO untouched and the receiver is quiet; saturates at TO_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (activity || rx.rx_busy || rx_empty)
                to_cnt <= '0;
            else if (baud_en_16x && to_cnt != TO_MAX)
                to_cnt <= to_cnt + TW'(1);

            // rx_busy alone restarts the count but leaves a raised flag set.
            if (activity || rx_empty)
                timeout <= 1'b0;
            else if (to_cnt == TO_MAX)
                timeout <= 1'b1;
        end
    end

    always_comb begin
        irq_next = 1'b0;
        if (ie[IE_LVL] && (rx_level >= thresh) && (thresh != '0)) irq_next = 1'b1;
        if (ie[IE_TO]  && timeout)                                irq_next = 1'b1;
        if (ie[IE_OVR] && overrun_err)                            irq_next = 1'b1;
        if (ie[IE_ERR] && (parity_err || frame_err))              irq_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= irq_next;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en_16x;
    logic       rx_en;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rx_full;
    logic [3:0] rx_level;
    logic [3:0] thresh;
    logic [3:0] ie;
    logic       err_clr;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       timeout;
    logic       irq;

    int n_asserts = 0;
    int n_fail    = 0;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_ctrl #(
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (8),
        .TIMEOUT_TICKS (704)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_en_16x (baud_en_16x),
        .rx          (rx_if),
        .rx_en       (rx_en),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_level    (rx_level),
        .thresh      (thresh),
        .ie          (ie),
        .err_clr     (err_clr),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .timeout     (timeout),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_if.rx_data  = d;
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"},  32'(rx_empty),    32'd1);
        chk({tag, "_full"},   32'(rx_full),     32'd0);
        chk({tag, "_level"},  32'(rx_level),    32'd0);
        chk({tag, "_rddata"}, 32'(rd_data),     32'd0);
        chk({tag, "_par"},    32'(parity_err),  32'd0);
        chk({tag, "_frm"},    32'(frame_err),   32'd0);
        chk({tag, "_ovr"},    32'(overrun_err), 32'd0);
        chk({tag, "_to"},     32'(timeout),     32'd0);
        chk({tag, "_irq"},    32'(irq),         32'd0);
    endtask

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};

        rst_n          = 1'b0;
        baud_en_16x    = 1'b0;
        rx_en          = 1'b1;
        rd_en          = 1'b0;
        thresh         = 4'd0;
        ie             = 4'b0000;
        err_clr        = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_ready = 1'b0;
        rx_if.rx_busy  = 1'b0;
        rx_if.rx_error = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_state("rst");
        rst_n = 1'b1;
        tick();

        // Fill 0x11..0x88 with a level interrupt armed at 8
        thresh = 4'd8;
        ie     = 4'b0001;
        for (int i = 1; i <= 8; i++) push(8'(i * 17));
        chk("fill_full",  32'(rx_full),  32'd1);
        chk("fill_level", 32'(rx_level), 32'd8);
        chk("fill_head",  32'(rd_data),  32'h11);
        chk("lvl_irq_latency", 32'(irq), 32'd0);
        tick();
        chk("lvl_irq", 32'(irq), 32'd1);
        ie = 4'b0000;
        tick();

        // Overrun while full
        push(8'h99);
        chk("ovr_flag",  32'(overrun_err), 32'd1);
        chk("ovr_level", 32'(rx_level),    32'd8);
        chk("ovr_head",  32'(rd_data),     32'h11);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun_err), 32'd0);

        // Push and pop together at full
        rx_if.rx_data  = 8'hAA;
        rx_if.rx_ready = 1'b1;
        rd_en          = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        rd_en          = 1'b0;
        chk("pp_full_level", 32'(rx_level),    32'd8);
        chk("pp_full_ovr",   32'(overrun_err), 32'd0);
        chk("pp_full_head",  32'(rd_data),     32'h22);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(drain_exp[i]));
            pop();
        end
        chk("drain_empty", 32'(rx_empty), 32'd1);
        chk("drain_level", 32'(rx_level), 32'd0);

        // Pop while empty is ignored
        pop();
        chk("underflow_level", 32'(rx_level), 32'd0);
        chk("underflow_empty", 32'(rx_empty), 32'd1);

        // Push and pop together at empty
        rx_if.rx_data  = 8'h5C;
        rx_if.rx_ready = 1'b1;
        rd_en          = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        rd_en          = 1'b0;
        chk("pp_empty_level", 32'(rx_level), 32'd1);
        chk("pp_empty_head",  32'(rd_data),  32'h5C);
        pop();
        chk("pp_empty_drain", 32'(rx_empty), 32'd1);

        // Parity error: character still stored
        rx_if.rx_data  = 8'hA5;
        rx_if.rx_ready = 1'b1;
        rx_if.rx_error = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        rx_if.rx_error = 1'b0;
        chk("par_flag",  32'(parity_err), 32'd1);
        chk("par_frm",   32'(frame_err),  32'd0);
        chk("par_level", 32'(rx_level),   32'd1);
        chk("par_head",  32'(rd_data),    32'hA5);
        tick();

        // Frame error: no push
        rx_if.rx_error = 1'b1;
        tick();
        rx_if.rx_error = 1'b0;
        chk("frm_flag",  32'(frame_err), 32'd1);
        chk("frm_level", 32'(rx_level),  32'd1);
        ie = 4'b1000;
        tick();
        chk("err_irq", 32'(irq), 32'd1);
        ie = 4'b0000;

        // Clear, then set-wins-over-clear
        err_clr = 1'b1;
        tick();
        chk("errclr_par", 32'(parity_err), 32'd0);
        chk("errclr_frm", 32'(frame_err),  32'd0);
        rx_if.rx_error = 1'b1;
        tick();
        rx_if.rx_error = 1'b0;
        chk("set_wins", 32'(frame_err), 32'd1);
        tick();
        err_clr = 1'b0;
        chk("set_wins_clr", 32'(frame_err), 32'd0);

        // rx_en=0 discards characters and errors
        rx_en          = 1'b0;
        rx_if.rx_error = 1'b1;
        push(8'h77);
        rx_if.rx_error = 1'b0;
        rx_en          = 1'b1;
        chk("dis_level", 32'(rx_level),   32'd1);
        chk("dis_par",   32'(parity_err), 32'd0);
        chk("dis_head",  32'(rd_data),    32'hA5);

        // Timeout with one character stored
        ie = 4'b0010;
        for (int i = 0; i < 702; i++) begin
            baud_en_16x = 1'b1;
            tick();
            baud_en_16x = 1'b0;
            tick();
        end
        chk("to_early", 32'(timeout), 32'd0);
        for (int i = 0; i < 2; i++) begin
            baud_en_16x = 1'b1;
            tick();
            baud_en_16x = 1'b0;
            tick();
        end
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_irq",  32'(irq),     32'd1);
        pop();
        chk("to_clr_pop",   32'(timeout),  32'd0);
        chk("to_pop_empty", 32'(rx_empty), 32'd1);
        ie = 4'b0000;
        tick();

        // Reset asserted mid-fill
        thresh = 4'd1;
        ie     = 4'b0001;
        push(8'h01);
        push(8'h02);
        rx_if.rx_error = 1'b1;
        tick();
        rx_if.rx_error = 1'b0;
        chk("pre_rst_frm", 32'(frame_err), 32'd1);
        chk("pre_rst_irq", 32'(irq),       32'd1);
        rx_if.rx_data  = 8'h03;
        rx_if.rx_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        tick();
        rx_if.rx_ready = 1'b0;
        rst_n          = 1'b1;
        ie             = 4'b0000;
        tick();
        chk("post_rst_level", 32'(rx_level), 32'd0);
        chk("post_rst_empty", 32'(rx_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: received character width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: RX FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 704: idle character-timeout in baud_en_16x ticks (4 chars x 11 bits x 16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port baud_en_16x, input, 1 bit: 16x oversample tick.
REQ-007 SHALL have ports rx_data (input, DATA_WIDTH), rx_ready (input, 1), rx_busy (input, 1) and rx_error (input, 1): receiver outputs.
REQ-008 SHALL have port rx_en, input, 1 bit: receive enable; 0 discards incoming characters.
REQ-009 SHALL have port rd_en, input, 1 bit: pop request from the register side.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH: FIFO head, valid when rx_empty=0.
REQ-011 SHALL have ports rx_empty (output, 1), rx_full (output, 1) and rx_level (output, $clog2(FIFO_DEPTH)+1): FIFO status.
REQ-012 SHALL have ports thresh (input, $clog2(FIFO_DEPTH)+1) and ie (input, 4): interrupt level threshold and enables {err, ovr, to, lvl}.
REQ-013 SHALL have ports err_clr (input, 1), parity_err, frame_err, overrun_err and timeout (all output, 1): sticky flags.
REQ-014 SHALL have port irq, output, 1 bit: combined interrupt.

Function
REQ-015 SHALL decode rx_error and rx_ready in the same cycle as a parity error; the character SHALL still be pushed.
REQ-016 SHALL decode a rising edge of rx_error with rx_ready=0 as a frame error; no push SHALL occur.
REQ-017 SHALL push rx_data on each rx_ready pulse when rx_en=1 and the FIFO is not full.
REQ-018 SHALL, on rx_ready with the FIFO full, drop the character and set overrun_err; FIFO contents SHALL be unchanged.
REQ-019 SHALL show the new head on rd_data with zero read latency; rd_en with rx_empty=1 SHALL be ignored with no underflow.
REQ-020 SHALL, on simultaneous push and pop with the FIFO full, perform both, leave rx_level unchanged and set no overrun.
REQ-021 SHALL, on simultaneous push and pop with the FIFO empty, accept the push, ignore the pop and end at rx_level=1.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH; rx_level SHALL range 0..FIFO_DEPTH.
REQ-023 SHALL hold parity_err, frame_err and overrun_err set until err_clr=1; a set event in the clear cycle SHALL win.
REQ-024 SHALL increment the timeout counter on baud_en_16x while rx_empty=0, rx_busy=0 and no push/pop occurs.
REQ-025 SHALL reset the timeout counter on any push, pop, rx_busy=1 or rx_empty=1.
REQ-026 SHALL set timeout when the count reaches TIMEOUT_TICKS-1 and saturate the counter there.
REQ-027 SHALL clear timeout on the next pop or push, or when the FIFO becomes empty.
REQ-028 SHALL compute irq as the registered OR of (ie[0] & rx_level>=thresh & thresh!=0), (ie[1] & timeout), (ie[2] & overrun_err) and (ie[3] & (parity_err|frame_err)); irq SHALL have one-cycle latency.
REQ-029 SHALL, when rx_en=0, push nothing and set no error flags; the FIFO SHALL remain readable.

Reset
REQ-030 SHALL, when rst_n=0, asynchronously clear pointers, rx_level=0, rx_empty=1, rx_full=0, rd_data=0, all sticky flags=0, timeout counter=0, irq=0 and the rx_error edge register=0.
REQ-031 SHALL discard any data in flight when reset asserts mid-operation; no pending push SHALL survive reset.

Structure
REQ-032 SHALL place the IRQ-enable bit indices, the default TIMEOUT_TICKS and the level-width function in the shared UART package used by uart_rx and the APB wrapper.
REQ-033 SHALL contain one sub-module, uart_sync_fifo (parameterised DATA_WIDTH/FIFO_DEPTH; push, pop, full, empty, level); the error, timeout and IRQ logic SHALL stay in uart_rx_ctrl.

Verification
REQ-034 SHALL verify fill and drain: push 0x11..0x88 (8 chars) -> rx_full=1 and rx_level=8; 8 pops return 0x11..0x88 in order, then rx_empty=1.
REQ-035 SHALL verify overrun: 9th rx_ready with data 0x99 while full -> overrun_err=1; head still 0x11; err_clr clears the flag the next cycle.
REQ-036 SHALL verify parity and frame errors: rx_ready with rx_error=1 and data 0xA5 -> parity_err=1 and 0xA5 stored; rx_error pulse without rx_ready -> frame_err=1 and level unchanged.
REQ-037 SHALL verify timeout: 1 char stored, rx_busy=0 for 704 ticks -> timeout=1 and irq=1 (ie=4'b0010); one pop -> timeout=0.
REQ-038 SHALL verify boundaries: push and pop in the same cycle at full -> level stays 8; push and pop in the same cycle at empty -> level 1; rst_n low mid-fill -> all outputs at reset values.
